// File: rtl/conv_code_pkg.sv
// Shared constants, FSM state type and tap-parity helper for the rate-1/2, K=3
// convolutional encoder array.
package conv_code_pkg;

  localparam int K       = 3;
  localparam int STATE_W = K - 1;

  localparam logic [K-1:0] G0_DEF = 3'b111;
  localparam logic [K-1:0] G1_DEF = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  // Generator output for window w = {d, s1, s0} against tap mask g.
  function automatic logic tap_parity(input logic [K-1:0] w, input logic [K-1:0] g);
    return ^(w & g);
  endfunction

endpackage

// File: rtl/viterbi_enc_lane.sv
// One encoder lane: payload shift register, {s1,s0} state and two generator XOR
// trees. Optional end_state output under VITERBI_ENC_STATE_OUT_EN.
module viterbi_enc_lane
  import conv_code_pkg::*;
#(
  parameter int             K_BITS = 8,
  parameter int             CNT_W  = 3,
  parameter logic [K-1:0]   G0     = G0_DEF,
  parameter logic [K-1:0]   G1     = G1_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [CNT_W-1:0]      bit_idx,
  input  logic [K_BITS-1:0]     data_in,
`ifdef VITERBI_ENC_STATE_OUT_EN
  input  logic                  last,
  output logic [STATE_W-1:0]    end_state,
`endif
  output logic [2*K_BITS-1:0]   code_out
);

  logic [K_BITS-1:0]   data_q,  data_d;
  logic [STATE_W-1:0]  st_q,    st_d;
  logic [2*K_BITS-1:0] code_q,  code_d;
  logic                d;
  logic [K-1:0]        w;
  logic                g0, g1;
`ifdef VITERBI_ENC_STATE_OUT_EN
  logic [STATE_W-1:0]  end_q,   end_d;
`endif

  always_comb begin
    data_d = data_q;
    st_d   = st_q;
    code_d = code_q;
`ifdef VITERBI_ENC_STATE_OUT_EN
    end_d  = end_q;
`endif
    // The payload is consumed LSB first, so the current bit is always bit 0.
    d  = data_q[0];
    w  = {d, st_q};
    g0 = tap_parity(w, G0);
    g1 = tap_parity(w, G1);

    if (load) begin
      data_d = data_in;
      st_d   = '0;
      code_d = '0;
    end else if (step) begin
      data_d = data_q >> 1;
      st_d   = {d, st_q[STATE_W-1]};
      for (int n = 0; n < K_BITS; n++) begin
        if (bit_idx == CNT_W'(n)) begin
          code_d[2*n+1] = g0;
          code_d[2*n]   = g1;
        end
      end
`ifdef VITERBI_ENC_STATE_OUT_EN
      if (last) end_d = {d, st_q[STATE_W-1]};
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      st_q   <= '0;
      code_q <= '0;
`ifdef VITERBI_ENC_STATE_OUT_EN
      end_q  <= '0;
`endif
    end else begin
      data_q <= data_d;
      st_q   <= st_d;
      code_q <= code_d;
`ifdef VITERBI_ENC_STATE_OUT_EN
      end_q  <= end_d;
`endif
    end
  end

  assign code_out = code_q;
`ifdef VITERBI_ENC_STATE_OUT_EN
  assign end_state = end_q;
`endif

endmodule

// File: rtl/viterbi_encoder.sv
// 24-lane rate-1/2 K=3 convolutional encoder: shared FSM and bit counter drive
// all lanes in lockstep. Define VITERBI_ENC_STATE_OUT_EN to expose end_state.
module viterbi_encoder
  import conv_code_pkg::*;
#(
  parameter int           LANES  = 24,
  parameter int           K_BITS = 8,
  parameter logic [K-1:0] G0     = G0_DEF,
  parameter logic [K-1:0] G1     = G1_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [LANES*K_BITS-1:0]     data_in,
`ifdef VITERBI_ENC_STATE_OUT_EN
  output logic [STATE_W*LANES-1:0]    end_state,
`endif
  output logic [2*LANES*K_BITS-1:0]   code_out,
  output logic                        done,
  output logic                        busy
);

  localparam int CNT_W = (K_BITS > 1) ? $clog2(K_BITS) : 1;

  fsm_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              load, step, last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    done    = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        last = (cnt_q == CNT_W'(K_BITS - 1));
        if (last) state_d = DONE;
        else      cnt_d   = cnt_q + 1'b1;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    viterbi_enc_lane #(
      .K_BITS (K_BITS),
      .CNT_W  (CNT_W),
      .G0     (G0),
      .G1     (G1)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .step      (step),
      .bit_idx   (cnt_q),
      .data_in   (data_in[K_BITS*i +: K_BITS]),
`ifdef VITERBI_ENC_STATE_OUT_EN
      .last      (last),
      .end_state (end_state[STATE_W*i +: STATE_W]),
`endif
      .code_out  (code_out[2*K_BITS*i +: 2*K_BITS])
    );
  end

endmodule

// File: tb/tb_viterbi_encoder.sv
// Self-checking bench for viterbi_encoder: directed table, multi-cycle corner
// cases and randomized blocks against a polynomial reference model.
module tb_viterbi_encoder;

  localparam int LANES  = 24;
  localparam int K_BITS = 8;
  localparam int DW     = LANES * K_BITS;
  localparam int CW     = 2 * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [CW-1:0] code_out;
  logic          done, busy;
  logic [2*LANES-1:0] end_state_m;

  int errors = 0;
  int checks = 0;

`ifdef VITERBI_ENC_STATE_OUT_EN
  logic [2*LANES-1:0] end_state;
  assign end_state_m = end_state;
`else
  assign end_state_m = '0;
`endif

  viterbi_encoder dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data_in  (data_in),
`ifdef VITERBI_ENC_STATE_OUT_EN
    .end_state(end_state),
`endif
    .code_out (code_out),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Code bit pair n from the generator polynomials over d[n], d[n-1], d[n-2].
  function automatic logic [15:0] enc_byte(input logic [7:0] b);
    logic [9:0]  x;
    logic [15:0] c;
    x = {b, 2'b00};
    c = '0;
    for (int n = 0; n < 8; n++) begin
      c[2*n+1] = x[n+2] ^ x[n+1] ^ x[n];
      c[2*n]   = x[n+2] ^ x[n];
    end
    return c;
  endfunction

  function automatic logic [CW-1:0] model_code(input logic [DW-1:0] d);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[16*i +: 16] = enc_byte(d[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [2*LANES-1:0] model_state(input logic [DW-1:0] d);
    logic [2*LANES-1:0] r;
    for (int i = 0; i < LANES; i++) r[2*i +: 2] = {d[8*i+7], d[8*i+6]};
    return r;
  endfunction

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_block(input logic [DW-1:0] d);
    @(negedge clk);
    data_in = d;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Called on the negedge right after the accepting edge; that edge counts as clock 1.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 1;
    bcnt = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
    if (busy) bcnt++;
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  task automatic finish_check(input string name, input logic [DW-1:0] d, input int cyc, input int bcnt);
    check({name, " latency"}, CW'(cyc), CW'(9));
    check({name, " busy_cycles"}, CW'(bcnt), CW'(9));
    check({name, " code"}, code_out, model_code(d));
`ifdef VITERBI_ENC_STATE_OUT_EN
    check({name, " end_state"}, CW'(end_state_m), CW'(model_state(d)));
`endif
    @(negedge clk);
    check({name, " done_width"}, CW'({done, busy}), CW'(2'b00));
  endtask

  task automatic run_block(input logic [DW-1:0] d, input string name);
    int cyc, bcnt;
    start_block(d);
    wait_done(cyc, bcnt);
    finish_check(name, d, cyc, bcnt);
  endtask

  typedef struct {
    int          lane;
    logic [7:0]  val;
    logic [15:0] exp_code;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [DW-1:0]      d, d2;
    logic [CW-1:0]      exp;
    logic [2*LANES-1:0] exp_st;
    int                 cyc, bcnt, nd;

    vecs[0] = '{lane: 0,  val: 8'h00, exp_code: 16'h0000, exp_state: 2'b00};
    vecs[1] = '{lane: 0,  val: 8'h01, exp_code: 16'h003B, exp_state: 2'b00};
    vecs[2] = '{lane: 0,  val: 8'hFF, exp_code: 16'hAAA7, exp_state: 2'b11};
    vecs[3] = '{lane: 23, val: 8'h01, exp_code: 16'h003B, exp_state: 2'b00};
    vecs[4] = '{lane: 12, val: 8'h80, exp_code: 16'hC000, exp_state: 2'b10};
    vecs[5] = '{lane: 7,  val: 8'h03, exp_code: 16'h00D7, exp_state: 2'b00};

    repeat (3) @(negedge clk);
    check("reset outputs", CW'({code_out, done, busy}), CW'(0));
    check("reset end_state", CW'(end_state_m), CW'(0));
    reset = 1'b0;
    @(negedge clk);
    check("idle outputs", CW'({done, busy}), CW'(0));

    // Directed single-lane vectors with hand-derived code words.
    for (int v = 0; v < 6; v++) begin
      d = '0;
      d[8*vecs[v].lane +: 8] = vecs[v].val;
      exp = '0;
      exp[16*vecs[v].lane +: 16] = vecs[v].exp_code;
      exp_st = '0;
      exp_st[2*vecs[v].lane +: 2] = vecs[v].exp_state;
      start_block(d);
      wait_done(cyc, bcnt);
      check($sformatf("vec%0d latency", v), CW'(cyc), CW'(9));
      check($sformatf("vec%0d busy_cycles", v), CW'(bcnt), CW'(9));
      check($sformatf("vec%0d code", v), code_out, exp);
`ifdef VITERBI_ENC_STATE_OUT_EN
      check($sformatf("vec%0d end_state", v), CW'(end_state_m), CW'(exp_st));
`endif
      repeat (4) @(negedge clk);
      check($sformatf("vec%0d hold", v), code_out, exp);
    end

    // Start pulsed mid-RUN with different data is ignored.
    d  = {6{32'hA5C3_1E7F}};
    d2 = {6{32'h1234_5678}};
    start_block(d);
    repeat (2) @(negedge clk);
    data_in = d2;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    cyc = 4; bcnt = 3;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
    if (busy) bcnt++;
    finish_check("busy_start", d, cyc, bcnt);
    count_done(12, nd);
    check("busy_start extra done", CW'(nd), CW'(0));

    // Start held high: next block accepted on the first IDLE cycle.
    d  = {6{32'h0F0F_3C96}};
    d2 = {6{32'hDEAD_BEEF}};
    @(negedge clk);
    data_in = d;
    start   = 1'b1;
    @(negedge clk);
    wait_done(cyc, bcnt);
    check("held latency", CW'(cyc), CW'(9));
    check("held code", code_out, model_code(d));
    data_in = d2;
    @(negedge clk);
    check("held idle gap", CW'({done, busy}), CW'(0));
    @(negedge clk);
    start = 1'b0;
    check("held reaccept", CW'(busy), CW'(1));
    wait_done(cyc, bcnt);
    finish_check("held second", d2, cyc, bcnt);

    // Reset during RUN aborts the block.
    start_block({6{32'hFFFF_FFFF}});
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort outputs", CW'({code_out, done, busy}), CW'(0));
    check("abort end_state", CW'(end_state_m), CW'(0));
    @(negedge clk);
    reset = 1'b0;
    count_done(12, nd);
    check("abort no done", CW'(nd), CW'(0));
    check("abort code held zero", code_out, CW'(0));
    run_block({6{32'h8421_C3A5}}, "post_abort");

    // Randomized blocks.
    for (int r = 0; r < 16; r++) begin
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_block(d, $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
